// File: rtl/fios_pkg.sv
// Shared types and constants for the self-sequenced FIOS Montgomery PE.
package fios_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MSTEP,
    COL,
    FOLD,
    SUB,
    OUT
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_P = 2'd2;

  // Word index width; at least one bit so S=1 still has a legal index port.
  function automatic int idx_w(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/fios_word_mac.sv
// Word multiply-accumulate: t + a*b + m*p + cin split into a W-bit sum and
// a (W+2)-bit carry. The carry width covers the worst case of all-ones inputs.
module fios_word_mac #(
  parameter int W = 17
) (
  input  logic [W-1:0] t_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] m_i,
  input  logic [W-1:0] p_i,
  input  logic [W+1:0] cin_i,
  output logic [W-1:0] sum_o,
  output logic [W+1:0] cout_o
);

  localparam int AW = 2 * W + 2;

  logic [AW-1:0] acc;

  // Full-width accumulation, then split at the word boundary.
  always_comb begin
    acc    = AW'(t_i) + AW'(a_i) * AW'(b_i) + AW'(m_i) * AW'(p_i) + AW'(cin_i);
    sum_o  = acc[W-1:0];
    cout_o = acc[AW-1:W];
  end

endmodule

// File: rtl/fios_pe_seq.sv
// Self-sequenced FIOS Montgomery PE: loads A/B/P word-wise, computes
// A*B*R^-1 mod P (R = 2^(W*S)), optionally subtracts P once, then streams
// the result LS word first over a ready/valid port.
module fios_pe_seq
  import fios_pkg::*;
#(
  parameter int W         = 17,
  parameter int S         = 4,
  parameter int FINAL_SUB = 1,
  parameter int IDX_W     = idx_w(S)  // derived, leave at default
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [1:0]       load_sel_i,
  input  logic [IDX_W-1:0] load_idx_i,
  input  logic [W-1:0]     load_data_i,
  input  logic [W-1:0]     p_prime_0_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [W-1:0]     res_data_o,
  output logic             res_last_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(S - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t state_q, state_d;

  logic [S-1:0][W-1:0] a_q, b_q, p_q;   // operand storage, not reset
  logic [S-1:0][W-1:0] t_q, d_q;        // running T and T-P
  logic                t_top_q;         // T[S]
  logic [W+1:0]        carry_q;
  logic [W-1:0]        m_q, pp_q;
  logic [IDX_W-1:0]    i_q, j_q;
  logic                borrow_q, sel_t_q, done_q;

  logic [W-1:0]        a_i, x_lo, m_new, mac_t, mac_b, mac_p, mac_m, mac_sum;
  logic [W+1:0]        mac_cin, mac_cout;
  logic [W:0]          fold_y, diff;

  // Operand writes: only while idle, out-of-range index and sel=3 dropped.
  always_ff @(posedge clock_i) begin
    if (state_q == IDLE && load_valid_i && int'(load_idx_i) < S) begin
      case (load_sel_i)
        SEL_A:   a_q[load_idx_i] <= load_data_i;
        SEL_B:   b_q[load_idx_i] <= load_data_i;
        SEL_P:   p_q[load_idx_i] <= load_data_i;
        default: ;
      endcase
    end
  end

  // MSTEP quotient digit, the shared MAC operand mux, fold and subtract terms.
  always_comb begin
    a_i     = a_q[i_q];
    x_lo    = t_q[0] + a_i * b_q[0];
    m_new   = x_lo * pp_q;
    mac_t   = t_q[j_q];
    mac_b   = b_q[j_q];
    mac_p   = p_q[j_q];
    mac_m   = (state_q == MSTEP) ? m_new : m_q;
    mac_cin = (state_q == MSTEP) ? '0 : carry_q;
    fold_y  = carry_q[W:0] + (W+1)'(t_top_q);
    diff    = {1'b0, t_q[j_q]} - {1'b0, p_q[j_q]} - (W+1)'(borrow_q);
  end

  fios_word_mac #(.W(W)) u_mac (
    .t_i    (mac_t),
    .a_i    (a_i),
    .b_i    (mac_b),
    .m_i    (mac_m),
    .p_i    (mac_p),
    .cin_i  (mac_cin),
    .sum_o  (mac_sum),
    .cout_o (mac_cout)
  );

  // State register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state and status outputs.
  always_comb begin
    state_d      = state_q;
    load_ready_o = 1'b0;
    busy_o       = 1'b1;
    res_valid_o  = 1'b0;
    res_last_o   = 1'b0;
    res_data_o   = '0;
    done_o       = done_q;
    case (state_q)
      IDLE: begin
        load_ready_o = 1'b1;
        busy_o       = 1'b0;
        if (start_i) state_d = MSTEP;
      end
      MSTEP: state_d = (S == 1) ? FOLD : COL;
      COL:   if (j_q == LAST) state_d = FOLD;
      FOLD: begin
        if (i_q == LAST) state_d = (FINAL_SUB != 0) ? SUB : OUT;
        else             state_d = MSTEP;
      end
      SUB:   if (j_q == LAST) state_d = OUT;
      OUT: begin
        res_valid_o = 1'b1;
        res_last_o  = (j_q == LAST);
        res_data_o  = sel_t_q ? t_q[j_q] : d_q[j_q];
        if (res_ready_i && j_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers, sequenced by the state.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      t_q      <= '0;
      d_q      <= '0;
      t_top_q  <= 1'b0;
      carry_q  <= '0;
      m_q      <= '0;
      pp_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      borrow_q <= 1'b0;
      sel_t_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == OUT) && res_ready_i && (j_q == LAST);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            pp_q    <= p_prime_0_i;
            t_q     <= '0;
            t_top_q <= 1'b0;
            carry_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
          end
        end
        MSTEP: begin
          // Low word of the sum is zero by choice of m, only the carry moves on.
          m_q     <= m_new;
          carry_q <= mac_cout;
          j_q     <= (S > 1) ? ONE : '0;
        end
        COL: begin
          t_q[j_q - ONE] <= mac_sum;
          carry_q        <= mac_cout;
          j_q            <= (j_q == LAST) ? '0 : j_q + ONE;
        end
        FOLD: begin
          t_q[S-1] <= fold_y[W-1:0];
          t_top_q  <= fold_y[W];
          j_q      <= '0;
          borrow_q <= 1'b0;
          if (i_q == LAST) begin
            i_q     <= '0;
            sel_t_q <= 1'b1;  // unreduced T unless the subtract pass decides
          end else begin
            i_q <= i_q + ONE;
          end
        end
        SUB: begin
          d_q[j_q] <= diff[W-1:0];
          borrow_q <= diff[W];
          if (j_q == LAST) begin
            // T < P exactly when nothing sits in T[S] and T-P borrowed out.
            sel_t_q <= ~t_top_q & diff[W];
            j_q     <= '0;
          end else begin
            j_q <= j_q + ONE;
          end
        end
        OUT: begin
          if (res_ready_i) j_q <= (j_q == LAST) ? '0 : j_q + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
